// File: rtl/hs_pkt_fifo_pkg.sv
// Shared helpers for the hs packet FIFO: pointer sizing and the position of the
// last flag inside a stored {last,payload} word.
package hs_pkt_fifo_pkg;

  localparam int HS_DATA_WD_DEF = 1;
  localparam int HS_LAST_BIT    = HS_DATA_WD_DEF;

  function automatic int hs_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // The last flag sits just above the payload bits in every stored word.
  function automatic int hs_last_bit(input int data_wd);
    return data_wd;
  endfunction

endpackage

// File: rtl/hs_pkt_fifo_ram.sv
// hs_fifo_ram: 1W1R storage array of {last,payload} words, synchronous write and
// asynchronous read so the head entry falls through without a cycle of latency.
module hs_fifo_ram
  import hs_pkt_fifo_pkg::*;
#(
  parameter int WIDTH   = HS_DATA_WD_DEF + 1,
  parameter int DEPTH   = 16,
  parameter int ADDR_WD = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_WD-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [ADDR_WD-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hs_pkt_fifo.sv
// Packet-aware FWFT valid/ready/last FIFO behind the hs arbiter; counts whole packets held.
// Define HS_PKT_FIFO_SAF_EN for store-and-forward release with sticky deadlock err.
module hs_pkt_fifo
  import hs_pkt_fifo_pkg::*;
#(
  parameter  int DATA_WD = 1,
  parameter  int DEPTH   = 16,
  localparam int ADDR_WD = hs_log2(DEPTH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s_valid,
  input  logic [DATA_WD-1:0] s_payload,
  input  logic               s_last,
  output logic               s_ready,
  output logic               m_valid,
  output logic [DATA_WD-1:0] m_payload,
  output logic               m_last,
  input  logic               m_ready,
  output logic [ADDR_WD:0]   level,
  output logic [ADDR_WD:0]   pkt_cnt,
  output logic               err
);

  localparam int               LAST_BIT = hs_last_bit(DATA_WD);
  localparam logic [ADDR_WD:0] CNT_ONE  = 1;

  logic [ADDR_WD:0] wr_ptr;
  logic [ADDR_WD:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             pkt_in;
  logic             pkt_out;
  logic [DATA_WD:0] rd_word;

  // MSB of each pointer is the wrap bit, so equal low bits mean either empty or full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WD] != rd_ptr[ADDR_WD]) &&
                 (wr_ptr[ADDR_WD-1:0] == rd_ptr[ADDR_WD-1:0]);

  assign s_ready = !full;
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  assign pkt_in  = push & s_last;
  assign pkt_out = pop & m_last;

  hs_fifo_ram #(
    .WIDTH  (DATA_WD + 1),
    .DEPTH  (DEPTH),
    .ADDR_WD(ADDR_WD)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr[ADDR_WD-1:0]),
    .wdata({s_last, s_payload}),
    .raddr(rd_ptr[ADDR_WD-1:0]),
    .rdata(rd_word)
  );

  assign m_payload = rd_word[DATA_WD-1:0];
  assign m_last    = rd_word[LAST_BIT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_ONE;
      if (pop)  rd_ptr <= rd_ptr + CNT_ONE;
      case ({push, pop})
        2'b10:   level <= level + CNT_ONE;
        2'b01:   level <= level - CNT_ONE;
        default: level <= level;
      endcase
      case ({pkt_in, pkt_out})
        2'b10:   pkt_cnt <= pkt_cnt + CNT_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - CNT_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

`ifdef HS_PKT_FIFO_SAF_EN
  assign m_valid = !empty && (pkt_cnt != '0);

  // A full FIFO holding no last beat can never release anything: latch the deadlock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          err <= 1'b0;
    else if (full && (pkt_cnt == '0))   err <= 1'b1;
  end
`else
  assign m_valid = !empty;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_hs_pkt_fifo.sv
// Self-checking bench for hs_pkt_fifo: queue-based reference model compared every cycle
// plus directed literal checks; honours HS_PKT_FIFO_SAF_EN.
module tb_hs_pkt_fifo;

  localparam int DATA_WD = 1;
  localparam int DEPTH   = 16;
  localparam int ADDR_WD = 4;
`ifdef HS_PKT_FIFO_SAF_EN
  localparam bit SAF = 1'b1;
`else
  localparam bit SAF = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               s_valid = 1'b0;
  logic [DATA_WD-1:0] s_payload = '0;
  logic               s_last = 1'b0;
  logic               s_ready;
  logic               m_valid;
  logic [DATA_WD-1:0] m_payload;
  logic               m_last;
  logic               m_ready = 1'b0;
  logic [ADDR_WD:0]   level;
  logic [ADDR_WD:0]   pkt_cnt;
  logic               err;

  int total = 0;
  int bad   = 0;

  logic [DATA_WD:0] model_q[$];
  bit               model_err = 1'b0;
  bit               mdl_push;
  bit               mdl_pop;

  hs_pkt_fifo #(.DATA_WD(DATA_WD), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_valid  (s_valid),
    .s_payload(s_payload),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_payload(m_payload),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .level    (level),
    .pkt_cnt  (pkt_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic int model_lasts();
    int n = 0;
    foreach (model_q[i]) n += int'(model_q[i][DATA_WD]);
    return n;
  endfunction

  function automatic bit model_valid();
    return (model_q.size() > 0) && (!SAF || (model_lasts() > 0));
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {last,payload} beats updated from the rules alone.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_q.delete();
      model_err = 1'b0;
    end else begin
      mdl_push = s_valid && (model_q.size() < DEPTH);
      mdl_pop  = model_valid() && m_ready;
      if (SAF && (model_q.size() == DEPTH) && (model_lasts() == 0)) model_err = 1'b1;
      if (mdl_pop) void'(model_q.pop_front());
      if (mdl_push) model_q.push_back({s_last, s_payload});
    end
  end

  always @(negedge clk) begin
    check_output("s_ready", int'(s_ready), int'(model_q.size() < DEPTH));
    check_output("m_valid", int'(m_valid), int'(model_valid()));
    check_output("level", int'(level), model_q.size());
    check_output("pkt_cnt", int'(pkt_cnt), model_lasts());
    check_output("err", int'(err), int'(model_err));
    if (model_valid()) begin
      check_output("m_payload", int'(m_payload), int'(model_q[0][DATA_WD-1:0]));
      check_output("m_last", int'(m_last), int'(model_q[0][DATA_WD]));
    end
  end

  task automatic apply_stimulus(input bit v, input logic [DATA_WD-1:0] p, input bit l, input bit r);
    s_valid   = v;
    s_payload = p;
    s_last    = l;
    m_ready   = r;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    s_valid = 1'b0;
    m_ready = 1'b0;
    rstn    = 1'b0;
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int cycles;
    bit accepted;

    repeat (3) @(negedge clk);
    #1;
    rstn = 1'b1;

    // Reset then idle
    apply_stimulus(0, 0, 0, 0);
    check_output("t1_level", int'(level), 0);
    check_output("t1_pkt", int'(pkt_cnt), 0);
    check_output("t1_m_valid", int'(m_valid), 0);
    check_output("t1_s_ready", int'(s_ready), 1);
    check_output("t1_err", int'(err), 0);

    // Three-beat packet held with m_ready low
    apply_stimulus(1, 1, 0, 0);
    check_output("t2_valid_b1", int'(m_valid), int'(!SAF));
    apply_stimulus(1, 0, 0, 0);
    check_output("t2_valid_b2", int'(m_valid), int'(!SAF));
    apply_stimulus(1, 1, 1, 0);
    check_output("t2_valid_b3", int'(m_valid), 1);
    check_output("t2_level", int'(level), 3);
    check_output("t2_pkt", int'(pkt_cnt), 1);
    check_output("t2_head_pay", int'(m_payload), 1);
    check_output("t2_head_last", int'(m_last), 0);
    repeat (3) apply_stimulus(0, 0, 0, 1);
    check_output("t2_drained", int'(level), 0);

    // Fill to DEPTH, then push+pop in the same cycle: pop only
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1, DATA_WD'(i & 1), (i % 4) == 3, 0);
    check_output("t3_level_full", int'(level), 16);
    check_output("t3_s_ready", int'(s_ready), 0);
    check_output("t3_pkt", int'(pkt_cnt), 4);
    apply_stimulus(1, 1, 0, 1);
    check_output("t3_level_pop", int'(level), 15);
    check_output("t3_pkt_pop", int'(pkt_cnt), 4);
    check_output("t3_head_pay", int'(m_payload), 1);
    repeat (15) apply_stimulus(0, 0, 0, 1);
    check_output("t3_drained", int'(level), 0);

    // Streaming 40 beats with random stalls across pointer wrap
    sent   = 0;
    cycles = 0;
    while (sent < 40 && cycles < 400) begin
      accepted = (model_q.size() < DEPTH);
      apply_stimulus(1, DATA_WD'(sent), ($urandom_range(0, 3) == 0) || (sent % 4 == 3),
                     $urandom_range(0, 9) < 7);
      if (accepted) sent++;
      cycles++;
    end
    check_output("t4_sent", sent, 40);
    repeat (40) apply_stimulus(0, 0, 0, 1);
    check_output("t4_drained", int'(level), 0);

    // Sixteen beats without a last
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1, DATA_WD'(i), 0, 0);
    apply_stimulus(0, 0, 0, 0);
`ifdef HS_PKT_FIFO_SAF_EN
    check_output("t5_err_set", int'(err), 1);
    check_output("t5_m_valid", int'(m_valid), 0);
    repeat (5) apply_stimulus(0, 0, 0, 1);
    check_output("t5_err_hold", int'(err), 1);
    check_output("t5_level_hold", int'(level), 16);
`else
    check_output("t5_err_ct", int'(err), 0);
    check_output("t5_m_valid_ct", int'(m_valid), 1);
    check_output("t5_pkt_ct", int'(pkt_cnt), 0);
`endif
    pulse_reset();
    check_output("t5_err_reset", int'(err), 0);
    check_output("t5_level_reset", int'(level), 0);

    // Reset mid-packet at level 5, then a clean 2-beat packet
    for (int i = 0; i < 5; i++) apply_stimulus(1, DATA_WD'(i), 0, 0);
    check_output("t6_level5", int'(level), 5);
    #2;
    rstn = 1'b0;
    #1;
    check_output("t6_rst_level", int'(level), 0);
    check_output("t6_rst_pkt", int'(pkt_cnt), 0);
    check_output("t6_rst_m_valid", int'(m_valid), 0);
    check_output("t6_rst_s_ready", int'(s_ready), 1);
    check_output("t6_rst_err", int'(err), 0);
    s_valid = 1'b0;
    @(negedge clk);
    #1;
    rstn = 1'b1;
    apply_stimulus(1, 1, 0, 0);
    apply_stimulus(1, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0);
    check_output("t6_level2", int'(level), 2);
    check_output("t6_pkt1", int'(pkt_cnt), 1);
    check_output("t6_m_valid", int'(m_valid), 1);
    check_output("t6_head1", int'(m_payload), 1);
    apply_stimulus(0, 0, 0, 1);
    check_output("t6_head2", int'(m_payload), 0);
    check_output("t6_last2", int'(m_last), 1);
    apply_stimulus(0, 0, 0, 1);
    check_output("t6_empty", int'(level), 0);
    check_output("t6_pkt0", int'(pkt_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
